// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS-subset sequencing controller with retired-instruction counter
// Optional MC_JUMP_EN adds the j (000010) instruction via the JUMP state.
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif

  state_t state_q;
  // run_q holds the FSM idle for the first edge after reset release
  logic   run_q;
  logic   legal_op;

  always_comb begin
    legal_op = (opcode == OP_LW) || (opcode == OP_SW) ||
               (opcode == OP_R)  || (opcode == OP_BEQ);
`ifdef MC_JUMP_EN
    if (opcode == OP_J) legal_op = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      run_q       <= 1'b0;
      instr_count <= '0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      if (instr_done) instr_count <= instr_count + COUNT_W'(1);
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_R:         state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
`ifdef MC_JUMP_EN
            OP_J:         state_q <= S_JUMP;
`endif
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_ALUWB;
        S_ALUWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
`ifdef MC_JUMP_EN
        S_JUMP:   state_q <= S_FETCH;
`endif
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // every output is forced low until run_q, which also covers rst_n low
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    state       = 4'd0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (run_q) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = !legal_op;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
`ifdef MC_JUMP_EN
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
`endif
        default: state = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
// Honours MC_JUMP_EN when checking opcode 000010.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [31:0] instr_count;

  logic        PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, IRWrite4;
  logic        MemtoReg4, ALUSrcA4, RegWrite4, RegDst4;
  logic [1:0]  PCSource4, ALUOp4, ALUSrcB4;
  logic [3:0]  state4;
  logic        instr_done4, illegal_op4;
  logic [3:0]  instr_count4;

  logic [21:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, state,
                 instr_done, illegal_op};

  int compared   = 0;
  int mismatched = 0;
  int exp_cnt    = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  multicycle_control #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4), .IorD(IorD4), .MemRead(MemRead4),
    .MemWrite(MemWrite4), .IRWrite(IRWrite4), .MemtoReg(MemtoReg4), .ALUSrcA(ALUSrcA4),
    .RegWrite(RegWrite4), .RegDst(RegDst4), .PCSource(PCSource4), .ALUOp(ALUOp4),
    .ALUSrcB(ALUSrcB4), .state(state4), .instr_done(instr_done4), .illegal_op(illegal_op4),
    .instr_count(instr_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled mid-cycle
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b0;
    nxt();
    nxt();
    #1 chk("reset_outs_zero", 32'(outs), 32'h0);
    chk("reset_count", instr_count, 32'd0);

    rst_n = 1'b1;
    #1 chk("release_outs_zero", 32'(outs), 32'h0);
    nxt();
    #1 chk("fetch_state", 32'(state), 32'd0);
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_alusrcb", 32'(ALUSrcB), 32'd1);
    chk("fetch_stall_irwrite", 32'(IRWrite), 32'd0);
    chk("fetch_stall_pcwrite", 32'(PCWrite), 32'd0);
    nxt();
    #1 chk("fetch_stall_hold", 32'(state), 32'd0);

    // lw, mem_ready held high
    opcode = 6'b100011; mem_ready = 1'b1;
    #1 chk("lw_fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("lw_fetch_pcwrite", 32'(PCWrite), 32'd1);
    nxt(); #1 chk("lw_s1", 32'(state), 32'd1);
    chk("lw_decode_alusrcb", 32'(ALUSrcB), 32'd3);
    chk("lw_decode_illegal", 32'(illegal_op), 32'd0);
    nxt(); #1 chk("lw_s2", 32'(state), 32'd2);
    chk("lw_memadr_ctl", 32'({ALUSrcA, ALUSrcB}), 32'b110);
    nxt(); #1 chk("lw_s3", 32'(state), 32'd3);
    chk("lw_memrd_ctl", 32'({MemRead, IorD}), 32'b11);
    nxt(); #1 chk("lw_s4", 32'(state), 32'd4);
    chk("lw_memwb_ctl", 32'({RegWrite, MemtoReg, instr_done}), 32'b111);
    chk("lw_count_before", instr_count, 32'd0);
    nxt(); #1 chk("lw_s0", 32'(state), 32'd0);
    exp_cnt = 1;
    chk("lw_count_after", instr_count, 32'(exp_cnt));

    // sw with two stall cycles in MEMWR
    opcode = 6'b101011;
    nxt(); #1 chk("sw_s1", 32'(state), 32'd1);
    nxt(); #1 chk("sw_s2", 32'(state), 32'd2);
    nxt(); mem_ready = 1'b0;
    #1 chk("sw_wr1_state", 32'(state), 32'd5);
    chk("sw_wr1_ctl", 32'({MemWrite, IorD, instr_done}), 32'b110);
    nxt(); #1 chk("sw_wr2_state", 32'(state), 32'd5);
    chk("sw_wr2_ctl", 32'({MemWrite, IorD, instr_done}), 32'b110);
    nxt(); mem_ready = 1'b1;
    #1 chk("sw_wr3_state", 32'(state), 32'd5);
    chk("sw_wr3_ctl", 32'({MemWrite, IorD, instr_done}), 32'b111);
    nxt(); #1 chk("sw_s0", 32'(state), 32'd0);
    exp_cnt = 2;
    chk("sw_count", instr_count, 32'(exp_cnt));

    // R-type then beq
    opcode = 6'b000000;
    nxt(); #1 chk("r_s1", 32'(state), 32'd1);
    nxt(); #1 chk("r_s6", 32'(state), 32'd6);
    chk("r_exec_ctl", 32'({ALUSrcA, ALUOp, PCWriteCond}), 32'b1100);
    nxt(); #1 chk("r_s7", 32'(state), 32'd7);
    chk("r_aluwb_ctl", 32'({RegDst, RegWrite, instr_done, MemtoReg}), 32'b1110);
    nxt(); #1 chk("r_s0", 32'(state), 32'd0);
    opcode = 6'b000100;
    nxt(); #1 chk("beq_s1", 32'(state), 32'd1);
    nxt(); #1 chk("beq_s8", 32'(state), 32'd8);
    chk("beq_ctl", 32'({ALUSrcA, ALUOp, PCWriteCond, PCSource, instr_done}), 32'b1011011);
    nxt(); #1 chk("beq_s0", 32'(state), 32'd0);
    exp_cnt = 4;
    chk("rbeq_count", instr_count, 32'(exp_cnt));

    // illegal opcode
    opcode = 6'b111111;
    nxt(); #1 chk("ill_s1", 32'(state), 32'd1);
    chk("ill_pulse", 32'({illegal_op, instr_done}), 32'b10);
    nxt(); #1 chk("ill_s0", 32'(state), 32'd0);
    chk("ill_pulse_end", 32'(illegal_op), 32'd0);
    chk("ill_count", instr_count, 32'(exp_cnt));

    // opcode 000010: jump when enabled, illegal otherwise
    opcode = 6'b000010;
    nxt(); #1 chk("j_s1", 32'(state), 32'd1);
`ifdef MC_JUMP_EN
    chk("j_decode_illegal", 32'(illegal_op), 32'd0);
    nxt(); #1 chk("j_s9", 32'(state), 32'd9);
    chk("j_ctl", 32'({PCWrite, PCSource, instr_done}), 32'b1101);
    exp_cnt = exp_cnt + 1;
`else
    chk("j_decode_illegal", 32'(illegal_op), 32'd1);
`endif
    nxt(); #1 chk("j_s0", 32'(state), 32'd0);
    chk("j_count", instr_count, 32'(exp_cnt));

    // reset pulse while stalled in MEMRD
    opcode = 6'b100011;
    nxt(); nxt(); nxt();
    mem_ready = 1'b0;
    #1 chk("rst_pre_state", 32'(state), 32'd3);
    chk("rst_pre_memread", 32'(MemRead), 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_async_outs", 32'(outs), 32'h0);
    chk("rst_async_count", instr_count, 32'd0);
    nxt(); #1 chk("rst_hold_outs", 32'(outs), 32'h0);
    rst_n = 1'b1;
    nxt(); #1 chk("rst_restart_state", 32'(state), 32'd0);
    chk("rst_restart_memread", 32'(MemRead), 32'd1);
    chk("rst_restart_count", instr_count, 32'd0);

    // 16 R-type instructions: 4-bit counter wraps
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      nxt(); nxt(); nxt(); nxt();
    end
    #1 chk("wrap_c4_15", 32'(instr_count4), 32'd15);
    nxt(); nxt(); nxt(); nxt();
    #1 chk("wrap_c4_0", 32'(instr_count4), 32'd0);
    chk("wrap_c32_16", instr_count, 32'd16);
    chk("wrap_state", 32'(state4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
